sdram_mport_arbiter: RTL and testbench
======================================

# sdram_mport_arbiter

Parametrised multi-port burst arbiter and address generator for the SDRAM path of the convolution engine. It serves NWR write ports and NRD read ports, each with its own base, max, length and load controls, and grants one burst at a time. Grants are round-robin or fixed-priority. For the granted burst it drives the command handshake (CMD/ADDR/LENGTH, CMD_ACK, DONE) of the downstream SDRAM command engine. Per-port address pointers wrap within [BASE, MAX), and a WRAP pulse is emitted for frame synchronisation.

## Interface
- ASIZE, 23: SDRAM word-address width.
- LSIZE, 12: burst-length width.
- USIZE, 16: FIFO used-word count width.
- NWR, 2: number of write ports (≥1).
- NRD, 2: number of read ports (≥1).
- RD_DEPTH, 512: read-side FIFO depth in words.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Port index convention: requester k = 0..NWR-1 is write port k; requester NWR+j is read port j. Per-port buses are flattened, port i occupying slice [i*W +: W].

- CLK  in  1  sole clock; everything is sampled on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- WR_LEVEL  in  NWR*USIZE  words available in each write FIFO (read side).
- WR_BASE, WR_MAX  in  NWR*ASIZE  per-port start address / exclusive limit.
- WR_LENGTH  in  NWR*LSIZE  per-port burst length.
- WR_LOAD  in  NWR  per-port pointer load to BASE; port is ineligible while high.
- RD_LEVEL  in  NRD*USIZE  words held in each read FIFO (write side).
- RD_BASE, RD_MAX, RD_LENGTH, RD_LOAD  in  as write side  read-port equivalents.
- CMD  out  2  00 = none, 01 = read burst, 10 = write burst.
- ADDR  out  ASIZE  start address of the granted burst.
- LENGTH  out  LSIZE  length of the granted burst.
- CMD_ACK  in  1  command engine accepted CMD.
- DONE  in  1  one-cycle pulse when the burst's data phase is finished.
- WR_GNT  out  NWR  one-hot; steers the write FIFO rdreq mask.
- RD_GNT  out  NRD  one-hot; steers the read FIFO wrreq mask.
- WR_WRAP  out  NWR  one-cycle pulse when a write pointer wraps to BASE.
- RD_WRAP  out  NRD  one-cycle pulse when a read pointer wraps to BASE.

## Operation
- Per-port state: pointer ptr (ASIZE bits) and a loaded flag.
  - Reset clears ptr to 0 and loaded to 0.
  - LOAD high sets ptr to BASE and loaded to 1, every cycle it is high.
- Eligibility (combinational, evaluated in IDLE only):
  - Write port: loaded, !LOAD, LENGTH≠0, and LEVEL ≥ LENGTH.
  - Read port: loaded, !LOAD, LENGTH≠0, and LEVEL + LENGTH ≤ RD_DEPTH. The sum is computed at USIZE+1 bits.
- Arbitration:
  - Round-robin: search upward, modulo NWR+NRD, starting at last_grant+1. last_grant resets to NWR+NRD-1, so requester 0 is searched first.
  - Fixed priority: lowest eligible index wins.
- FSM states: IDLE, ISSUE, BUSY, UPDATE.
  - IDLE → ISSUE when any requester is eligible. In that transition, register GNT, CMD, ADDR = ptr and LENGTH, and update last_grant.
  - ISSUE: hold CMD/ADDR/LENGTH stable until CMD_ACK is sampled high, then CMD = 00 and go to BUSY. DONE seen in ISSUE is ignored.
  - BUSY: on DONE go to UPDATE. CMD_ACK seen in BUSY is ignored.
  - UPDATE: advance the granted pointer, clear GNT, go to IDLE.
- Pointer advance (unsigned, ASIZE bits):
  - If ptr < MAX − LENGTH, ptr ← ptr + LENGTH.
  - Otherwise ptr ← BASE and the port's WRAP pulses.
  - If MAX < LENGTH, every advance wraps to BASE.
- LOAD overrides advance. If LOAD is high in UPDATE, ptr ← BASE and no WRAP is emitted.
- LOAD on the granted port during ISSUE/BUSY does not abort the burst. GNT stays until UPDATE.
- BASE/MAX/LENGTH changes take effect at the next grant. ADDR and LENGTH are latched at grant.

## Timing
- Reset values: CMD = 00, ADDR = 0, LENGTH = 0, all GNT = 0, all WRAP = 0, FSM = IDLE.
- Outputs are registered with no combinational input-to-output path.
- Eligible at IDLE edge t → CMD/GNT valid from t+1.
- CMD_ACK high at edge a → CMD = 00 from a+1.
- DONE at edge d → UPDATE during cycle d+1. GNT, WRAP and the new ptr take effect at d+2, which is also the first IDLE cycle.
- There is at least one IDLE cycle between bursts so that FIFO levels settle.
- Minimum burst overhead is 4 cycles (IDLE, ISSUE, BUSY, UPDATE).
- RESET asserted mid-burst returns the FSM to IDLE immediately and clears every pointer. Ports must be re-LOADed before they become eligible again.

## Test plan
- Reset, then no LOAD, with WR_LEVEL = 500 and LENGTH = 256 → no CMD ever issued; all outputs at their reset values.
- Write port 0 loaded with BASE = 0, MAX = 1024, LENGTH = 256, LEVEL = 256 → four bursts at ADDR 0, 256, 512, 768. Before the fifth burst WR_WRAP[0] pulses once and the next ADDR = 0.
- ARB_MODE = 0 with write ports 0 and 1 and read port 0 all continuously eligible → grant order 0, 1, 2, 0, 1, 2. With ARB_MODE = 1 the order is 0, 0, 0.
- Read port with RD_DEPTH = 512, LENGTH = 256: LEVEL = 257 → ineligible; LEVEL = 256 → granted with CMD = 01.
- CMD_ACK delayed 5 cycles → CMD, ADDR and LENGTH held stable for 5 cycles. A DONE pulse during ISSUE has no effect.
- Two cases checked separately:
  - WR_LOAD pulsed during BUSY with BASE = 4096 → burst completes, the next ADDR for that port = 4096, no WRAP.
  - RESET asserted during BUSY → CMD and GNT cleared within the reset assertion; FSM returns to IDLE.

Source files
------------

// File: rtl/sdram_mport_arbiter.sv
// sdram_mport_arbiter: multi-port SDRAM burst arbiter with per-port wrapping address pointers
module sdram_mport_arbiter #(
  parameter int ASIZE    = 23,
  parameter int LSIZE    = 12,
  parameter int USIZE    = 16,
  parameter int NWR      = 2,
  parameter int NRD      = 2,
  parameter int RD_DEPTH = 512,
  parameter int ARB_MODE = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NWR*USIZE-1:0]   WR_LEVEL,
  input  logic [NWR*ASIZE-1:0]   WR_BASE,
  input  logic [NWR*ASIZE-1:0]   WR_MAX,
  input  logic [NWR*LSIZE-1:0]   WR_LENGTH,
  input  logic [NWR-1:0]         WR_LOAD,
  input  logic [NRD*USIZE-1:0]   RD_LEVEL,
  input  logic [NRD*ASIZE-1:0]   RD_BASE,
  input  logic [NRD*ASIZE-1:0]   RD_MAX,
  input  logic [NRD*LSIZE-1:0]   RD_LENGTH,
  input  logic [NRD-1:0]         RD_LOAD,
  output logic [1:0]             CMD,
  output logic [ASIZE-1:0]       ADDR,
  output logic [LSIZE-1:0]       LENGTH,
  input  logic                   CMD_ACK,
  input  logic                   DONE,
  output logic [NWR-1:0]         WR_GNT,
  output logic [NRD-1:0]         RD_GNT,
  output logic [NWR-1:0]         WR_WRAP,
  output logic [NRD-1:0]         RD_WRAP
);
  localparam int N  = NWR + NRD;
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, UPDATE} state_t;
  state_t state_q, state_d;
  logic [ASIZE-1:0] ptr [N];
  logic [ASIZE-1:0] base [N];
  logic [ASIZE-1:0] lim [N];
  logic [LSIZE-1:0] len [N];
  logic [N-1:0] load, loaded, elig, adv_ok, gnt, wrap;
  logic [IW-1:0] sel, gidx, last_grant;
  logic any, reload_q;
  int c;
  assign load    = {RD_LOAD, WR_LOAD};
  assign WR_GNT  = gnt[NWR-1:0];
  assign RD_GNT  = gnt[N-1:NWR];
  assign WR_WRAP = wrap[NWR-1:0];
  assign RD_WRAP = wrap[N-1:NWR];
  for (genvar g = 0; g < NWR; g++) begin : g_wr
    assign base[g] = WR_BASE[g*ASIZE +: ASIZE];
    assign lim[g]  = WR_MAX[g*ASIZE +: ASIZE];
    assign len[g]  = WR_LENGTH[g*LSIZE +: LSIZE];
    assign elig[g] = loaded[g] && !WR_LOAD[g] && len[g] != '0 &&
                     (USIZE+1)'(WR_LEVEL[g*USIZE +: USIZE]) >= (USIZE+1)'(len[g]);
  end
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign base[NWR+g] = RD_BASE[g*ASIZE +: ASIZE];
    assign lim[NWR+g]  = RD_MAX[g*ASIZE +: ASIZE];
    assign len[NWR+g]  = RD_LENGTH[g*LSIZE +: LSIZE];
    assign elig[NWR+g] = loaded[NWR+g] && !RD_LOAD[g] && len[NWR+g] != '0 &&
                         (USIZE+1)'(RD_LEVEL[g*USIZE +: USIZE]) + (USIZE+1)'(len[NWR+g]) <= (USIZE+1)'(RD_DEPTH);
  end
  // MAX < LENGTH makes every advance wrap
  for (genvar g = 0; g < N; g++) begin : g_adv
    assign adv_ok[g] = lim[g] >= ASIZE'(len[g]) && ptr[g] < lim[g] - ASIZE'(len[g]);
  end
  // Scan from the farthest candidate down so the nearest eligible one is written last
  always_comb begin
    sel = '0;
    any = 1'b0;
    c   = 0;
    for (int k = N; k >= 1; k--) begin
      c = (ARB_MODE != 0) ? k - 1 : (int'(last_grant) + k) % N;
      if (elig[c]) begin
        sel = IW'(c);
        any = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any ? ISSUE : IDLE;
      ISSUE:   state_d = CMD_ACK ? BUSY : ISSUE;
      BUSY:    state_d = DONE ? UPDATE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      CMD        <= '0;
      ADDR       <= '0;
      LENGTH     <= '0;
      gnt        <= '0;
      wrap       <= '0;
      gidx       <= '0;
      last_grant <= IW'(N - 1);
      reload_q   <= 1'b0;
      loaded     <= '0;
      for (int i = 0; i < N; i++) ptr[i] <= '0;
    end else begin
      state_q <= state_d;
      wrap    <= '0;
      if (state_q == IDLE && any) begin
        gnt        <= N'(1) << sel;
        gidx       <= sel;
        last_grant <= sel;
        CMD        <= (int'(sel) < NWR) ? 2'b10 : 2'b01;
        ADDR       <= ptr[sel];
        LENGTH     <= len[sel];
        reload_q   <= 1'b0;
      end
      if (state_q == ISSUE && CMD_ACK) CMD <= 2'b00;
      // a reload during the burst already placed ptr at BASE; keep it there
      if (state_q != IDLE && load[gidx]) reload_q <= 1'b1;
      if (state_q == UPDATE) gnt <= '0;
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          ptr[i]    <= base[i];
          loaded[i] <= 1'b1;
        end else if (state_q == UPDATE && gidx == IW'(i) && !reload_q) begin
          ptr[i]  <= adv_ok[i] ? ptr[i] + ASIZE'(len[i]) : base[i];
          wrap[i] <= !adv_ok[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// tb_sdram_mport_arbiter: directed self-checking bench for the multi-port SDRAM arbiter
module tb_sdram_mport_arbiter;
  localparam int ASIZE = 23, LSIZE = 12, USIZE = 16, NWR = 2, NRD = 2;
  logic CLK = 1'b0, RESET = 1'b1;
  logic [NWR*USIZE-1:0] WR_LEVEL = '0;
  logic [NWR*ASIZE-1:0] WR_BASE = '0, WR_MAX = '0;
  logic [NWR*LSIZE-1:0] WR_LENGTH = '0;
  logic [NWR-1:0] WR_LOAD = '0;
  logic [NRD*USIZE-1:0] RD_LEVEL = '0;
  logic [NRD*ASIZE-1:0] RD_BASE = '0, RD_MAX = '0;
  logic [NRD*LSIZE-1:0] RD_LENGTH = '0;
  logic [NRD-1:0] RD_LOAD = '0;
  logic CMD_ACK = 1'b0, DONE = 1'b0;
  logic [1:0] CMD, fp_cmd;
  logic [ASIZE-1:0] ADDR, fp_addr;
  logic [LSIZE-1:0] LENGTH, fp_len;
  logic [NWR-1:0] WR_GNT, WR_WRAP, fp_wr_gnt, fp_wr_wrap;
  logic [NRD-1:0] RD_GNT, RD_WRAP, fp_rd_gnt, fp_rd_wrap;
  int n_cmp = 0, n_err = 0;
  logic [1:0] got_cmd;
  logic [ASIZE-1:0] got_addr;
  logic [LSIZE-1:0] got_len;
  logic [3:0] got_gnt, got_gnt_fp, got_wrap;
  int exp_addr [5] = '{0, 256, 512, 768, 0};
  int exp_wrap [5] = '{0, 0, 0, 1, 0};
  int exp_rr [6] = '{1, 2, 4, 1, 2, 4};
  sdram_mport_arbiter #(.ARB_MODE(0)) dut (
    .CLK(CLK), .RESET(RESET), .WR_LEVEL(WR_LEVEL), .WR_BASE(WR_BASE), .WR_MAX(WR_MAX),
    .WR_LENGTH(WR_LENGTH), .WR_LOAD(WR_LOAD), .RD_LEVEL(RD_LEVEL), .RD_BASE(RD_BASE),
    .RD_MAX(RD_MAX), .RD_LENGTH(RD_LENGTH), .RD_LOAD(RD_LOAD), .CMD(CMD), .ADDR(ADDR),
    .LENGTH(LENGTH), .CMD_ACK(CMD_ACK), .DONE(DONE), .WR_GNT(WR_GNT), .RD_GNT(RD_GNT),
    .WR_WRAP(WR_WRAP), .RD_WRAP(RD_WRAP)
  );
  sdram_mport_arbiter #(.ARB_MODE(1)) dut_fp (
    .CLK(CLK), .RESET(RESET), .WR_LEVEL(WR_LEVEL), .WR_BASE(WR_BASE), .WR_MAX(WR_MAX),
    .WR_LENGTH(WR_LENGTH), .WR_LOAD(WR_LOAD), .RD_LEVEL(RD_LEVEL), .RD_BASE(RD_BASE),
    .RD_MAX(RD_MAX), .RD_LENGTH(RD_LENGTH), .RD_LOAD(RD_LOAD), .CMD(fp_cmd), .ADDR(fp_addr),
    .LENGTH(fp_len), .CMD_ACK(CMD_ACK), .DONE(DONE), .WR_GNT(fp_wr_gnt), .RD_GNT(fp_rd_gnt),
    .WR_WRAP(fp_wr_wrap), .RD_WRAP(fp_rd_wrap)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_check(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge CLK);
      if (CMD != 2'b00) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask
  // One burst: wait for CMD, optionally delay ACK, then DONE; returns in the first IDLE cycle
  task automatic run_burst(input int dly, input bit done_iss, input bit ld_busy);
    int n = 0;
    while (CMD == 2'b00 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (CMD == 2'b00) begin
      check("cmd_wait", CMD != 2'b00, 1);
      got_cmd = 'x;
      got_addr = 'x;
      got_len = 'x;
      got_gnt = 'x;
      got_gnt_fp = 'x;
      got_wrap = 'x;
      return;
    end
    got_cmd    = CMD;
    got_addr   = ADDR;
    got_len    = LENGTH;
    got_gnt    = {RD_GNT, WR_GNT};
    got_gnt_fp = {fp_rd_gnt, fp_wr_gnt};
    for (int i = 0; i < dly; i++) begin
      DONE = done_iss && i == 1;
      @(negedge CLK);
      check("hold", {CMD, ADDR, LENGTH}, {got_cmd, got_addr, got_len});
    end
    DONE = 1'b0;
    CMD_ACK = 1'b1;
    @(negedge CLK);
    CMD_ACK = 1'b0;
    check("cmd_clr", CMD, 0);
    if (ld_busy) begin
      WR_LOAD[0] = 1'b1;
      @(negedge CLK);
      WR_LOAD[0] = 1'b0;
    end
    DONE = 1'b1;
    @(negedge CLK);
    DONE = 1'b0;
    @(negedge CLK);
    got_wrap = {RD_WRAP, WR_WRAP};
    check("gnt_clr", {RD_GNT, WR_GNT}, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge CLK);
    check("rst_cmd", CMD, 0);
    check("rst_addr", ADDR, 0);
    check("rst_len", LENGTH, 0);
    check("rst_gnt", {RD_GNT, WR_GNT}, 0);
    check("rst_wrap", {RD_WRAP, WR_WRAP}, 0);
    RESET = 1'b0;
    WR_LEVEL  = {16'd500, 16'd500};
    WR_LENGTH = {12'd256, 12'd256};
    WR_MAX    = {23'd1024, 23'd1024};
    idle_check("noload_idle", 20);
    check("noload_gnt", {RD_GNT, WR_GNT}, 0);
    WR_LEVEL[15:0]  = 16'd256;
    WR_LENGTH[23:12] = 12'd0;
    WR_LOAD = 2'b01;
    @(negedge CLK);
    WR_LOAD = 2'b00;
    for (int b = 0; b < 5; b++) begin
      run_burst(0, 1'b0, 1'b0);
      check($sformatf("seq%0d_cmd", b), got_cmd, 2);
      check($sformatf("seq%0d_addr", b), got_addr, exp_addr[b]);
      check($sformatf("seq%0d_len", b), got_len, 256);
      check($sformatf("seq%0d_gnt", b), got_gnt, 1);
      check($sformatf("seq%0d_wrap", b), got_wrap, exp_wrap[b]);
    end
    run_burst(5, 1'b1, 1'b0);
    check("slow_ack_addr", got_addr, 256);
    check("slow_ack_len", got_len, 256);
    WR_BASE[22:0] = 23'd4096;
    WR_MAX[22:0]  = 23'd8192;
    run_burst(0, 1'b0, 1'b1);
    check("ldbusy_addr", got_addr, 512);
    check("ldbusy_wrap", got_wrap, 0);
    run_burst(0, 1'b0, 1'b0);
    check("reload_addr", got_addr, 4096);
    WR_LENGTH = '0;
    do_reset();
    WR_BASE   = '0;
    WR_MAX    = {23'h100000, 23'h100000};
    WR_LENGTH = {12'd16, 12'd16};
    WR_LEVEL  = {16'd256, 16'd256};
    RD_MAX    = {23'h100000, 23'h100000};
    RD_LENGTH = {12'd0, 12'd16};
    RD_LEVEL  = '0;
    WR_LOAD = 2'b11;
    RD_LOAD = 2'b01;
    @(negedge CLK);
    WR_LOAD = 2'b00;
    RD_LOAD = 2'b00;
    for (int b = 0; b < 6; b++) begin
      run_burst(0, 1'b0, 1'b0);
      check($sformatf("rr%0d_gnt", b), got_gnt, exp_rr[b]);
      check($sformatf("rr%0d_cmd", b), got_cmd, exp_rr[b] == 4 ? 1 : 2);
      check($sformatf("fp%0d_gnt", b), got_gnt_fp, 1);
      if (b == 3) check("rr3_addr", got_addr, 16);
    end
    WR_LENGTH = '0;
    RD_LENGTH = '0;
    do_reset();
    RD_MAX[22:0]     = 23'd4096;
    RD_LENGTH[11:0]  = 12'd256;
    RD_LEVEL[15:0]   = 16'd257;
    RD_LOAD = 2'b01;
    @(negedge CLK);
    RD_LOAD = 2'b00;
    idle_check("rd_full_idle", 20);
    RD_LEVEL[15:0] = 16'd256;
    run_burst(0, 1'b0, 1'b0);
    check("rd_cmd", got_cmd, 1);
    check("rd_gnt", got_gnt, 4);
    check("rd_addr", got_addr, 0);
    check("rd_len", got_len, 256);
    for (int n = 0; n < 40 && CMD == 2'b00; n++) @(negedge CLK);
    check("rstb_cmd", CMD, 1);
    check("rstb_addr", ADDR, 256);
    CMD_ACK = 1'b1;
    @(negedge CLK);
    CMD_ACK = 1'b0;
    RESET = 1'b1;
    #1;
    check("rstb_cmd_clr", CMD, 0);
    check("rstb_gnt_clr", {RD_GNT, WR_GNT}, 0);
    @(negedge CLK);
    RESET = 1'b0;
    idle_check("rstb_idle", 20);
    check("rstb_addr_clr", ADDR, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
